fiapp_ctrl: RTL and testbench

- Self-checking sequencer for the fiapp fault-injection target datapath.
- Pulses the target's reset, then drives pseudo-random a/enable stimulus for a programmed number of cycles.
- Runs a cycle-exact golden model of q1/q2/q3/qext[64] and compares it against target outputs every cycle.
- Reports pass/fail, a saturating mismatch count and the first-mismatch cycle, so injected faults are detected in RTL without a testbench scoreboard.

---
 rtl/fiapp_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_fiapp_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fiapp_ctrl.sv
// Self-checking sequencer for the fiapp target: resets it, drives LFSR stimulus, and compares it against a golden model.
// Optional first-mismatch capture of {expected, observed} outputs is enabled by defining FIAPP_CTRL_ERRLOG_EN.
module fiapp_ctrl #(
    parameter int CNT_W        = 16,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_len,
    input  logic [15:0]      seed,
    output logic             dut_reset,
    output logic             dut_a,
    output logic             dut_enable,
    input  logic             dut_o1,
    input  logic             dut_o2,
    input  logic             dut_o3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic [5:0]       err_vec
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       ph_q, ph_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             dut_reset_q, dut_reset_d;
    logic             dut_a_q, dut_a_d;
    logic             dut_en_q, dut_en_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] first_err_q, first_err_d;
    logic             aborted_q, aborted_d;
    logic             gq1_q, gq1_d;
    logic             gq2_q, gq2_d;
    logic             gq3_q, gq3_d;
    logic [64:0]      gext_q, gext_d;

    logic             start_acc;
    logic             compare_en;
    logic             mismatch;
    logic [2:0]       exp_o;
    logic [2:0]       obs_o;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort only acts while a campaign is in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_RST;
            end
            S_RST: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (ph_q == 4'(RST_CYCLES - 1)) begin
                    state_d = (run_len_q == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (cyc_q == run_len_q - CNT_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (ph_q == 4'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RST, S_RUN, S_DRAIN: busy = 1'b1;
            S_DONE:                done = 1'b1;
            default: ;
        endcase
        pass = done && !aborted_q && (err_count_q == '0);
    end

    assign start_acc  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign compare_en = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign exp_o      = {gq1_q, gq2_q, gq3_q & gext_q[64]};
    assign obs_o      = {dut_o1, dut_o2, dut_o3};
    assign mismatch   = compare_en && (exp_o != obs_o);

    always_comb begin
        ph_d = '0;
        if (state_d == state_q && (state_q == S_RST || state_q == S_DRAIN)) begin
            ph_d = ph_q + 4'd1;
        end

        run_len_d   = run_len_q;
        lfsr_d      = lfsr_q;
        cyc_d       = cyc_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        aborted_d   = aborted_q;
        if (start_acc) begin
            run_len_d   = run_len;
            lfsr_d      = (seed == 16'h0000) ? 16'hACE1 : seed;
            cyc_d       = '0;
            err_count_d = '0;
            first_err_d = '0;
            aborted_d   = 1'b0;
        end else begin
            if (state_d == S_RUN) lfsr_d = lfsr_step(lfsr_q);
            if (compare_en) cyc_d = sat_inc(cyc_q);
            if (mismatch) begin
                err_count_d = sat_inc(err_count_q);
                if (err_count_q == '0) first_err_d = cyc_q;
            end
            if (abort && busy) aborted_d = 1'b1;
        end

        // Stimulus is registered against the upcoming state so it lines up with state_q
        dut_reset_d = (state_d == S_RST);
        dut_a_d     = (state_d == S_RUN) ? lfsr_q[0] : 1'b0;
        dut_en_d    = (state_d == S_RUN) ? lfsr_q[1] : 1'b0;
    end

    // Golden model of the target, fed by the same registered stimulus
    always_comb begin
        gq1_d  = '0;
        gq2_d  = '0;
        gq3_d  = '0;
        gext_d = '0;
        if (!dut_reset_q) begin
            gq1_d  = dut_en_q ? dut_a_q : gq1_q;
            gq2_d  = gq1_q;
            gq3_d  = !gq1_q;
            gext_d = gext_q + 65'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q        <= '0;
            cyc_q       <= '0;
            run_len_q   <= '0;
            lfsr_q      <= 16'hACE1;
            dut_reset_q <= 1'b1;
            dut_a_q     <= 1'b0;
            dut_en_q    <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            aborted_q   <= 1'b0;
            gq1_q       <= 1'b0;
            gq2_q       <= 1'b0;
            gq3_q       <= 1'b0;
            gext_q      <= '0;
        end else begin
            ph_q        <= ph_d;
            cyc_q       <= cyc_d;
            run_len_q   <= run_len_d;
            lfsr_q      <= lfsr_d;
            dut_reset_q <= dut_reset_d;
            dut_a_q     <= dut_a_d;
            dut_en_q    <= dut_en_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            aborted_q   <= aborted_d;
            gq1_q       <= gq1_d;
            gq2_q       <= gq2_d;
            gq3_q       <= gq3_d;
            gext_q      <= gext_d;
        end
    end

`ifdef FIAPP_CTRL_ERRLOG_EN
    logic [5:0] err_vec_q, err_vec_d;

    always_comb begin
        err_vec_d = err_vec_q;
        if (start_acc) begin
            err_vec_d = '0;
        end else if (mismatch && err_count_q == '0) begin
            err_vec_d = {exp_o, obs_o};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_vec_q <= '0;
        end else begin
            err_vec_q <= err_vec_d;
        end
    end

    assign err_vec = err_vec_q;
`else
    assign err_vec = 6'b0;
`endif

    assign dut_reset       = dut_reset_q;
    assign dut_a           = dut_a_q;
    assign dut_enable      = dut_en_q;
    assign err_count       = err_count_q;
    assign first_err_cycle = first_err_q;

endmodule

// File: tb/tb_fiapp_ctrl.sv
// Bench for fiapp_ctrl: a behavioural target with fault hooks, plus a per-campaign sequence model of expected results.
module tb_fiapp_ctrl;

    localparam int CW = 16;
    localparam int RSTC = 2;
    localparam int DRNC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, abort;
    logic [CW-1:0] run_len;
    logic [15:0]   seed;
    logic          dut_reset, dut_a, dut_enable;
    logic          dut_o1, dut_o2, dut_o3;
    logic          busy, done, pass;
    logic [CW-1:0] err_count, first_err_cycle;
    logic [5:0]    err_vec;

    logic          start2;
    logic [3:0]    run_len2;
    logic          d2_reset, d2_a, d2_en;
    logic          t2o1, t2o2, t2o3;
    logic          busy2, done2, pass2;
    logic [3:0]    err_count2, first_err2;
    logic [5:0]    err_vec2;

    int checks = 0;
    int failures = 0;

    fiapp_ctrl #(.CNT_W(CW), .RST_CYCLES(RSTC), .DRAIN_CYCLES(DRNC)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .run_len(run_len), .seed(seed),
        .dut_reset(dut_reset), .dut_a(dut_a), .dut_enable(dut_enable),
        .dut_o1(dut_o1), .dut_o2(dut_o2), .dut_o3(dut_o3),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_cycle(first_err_cycle), .err_vec(err_vec)
    );

    fiapp_ctrl #(.CNT_W(4), .RST_CYCLES(RSTC), .DRAIN_CYCLES(DRNC)) u_dut4 (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0),
        .run_len(run_len2), .seed(16'h0001),
        .dut_reset(d2_reset), .dut_a(d2_a), .dut_enable(d2_en),
        .dut_o1(t2o1), .dut_o2(t2o2), .dut_o3(t2o3),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_err_cycle(first_err2), .err_vec(err_vec2)
    );

    // Behavioural fiapp target; fmode 1 forces o1 high, fmode 2 forces o2 high, from compare cycle fk on
    logic        tq1, tq2, tq3;
    logic [64:0] text;
    int          tcyc;
    int          fmode = 0;
    int          fk = 0;

    always @(posedge clk) begin
        if (dut_reset) begin
            tq1 <= 1'b0; tq2 <= 1'b0; tq3 <= 1'b0; text <= '0; tcyc <= 0;
        end else begin
            if (dut_enable) tq1 <= dut_a;
            tq2  <= tq1;
            tq3  <= !tq1;
            text <= text + 65'd1;
            if (busy) tcyc <= tcyc + 1;
        end
    end

    assign dut_o1 = (fmode == 1 && tcyc >= fk) ? 1'b1 : tq1;
    assign dut_o2 = (fmode == 2 && tcyc >= fk) ? 1'b1 : tq2;
    assign dut_o3 = tq3 & text[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] fb;
        fb = 16'((s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001);
        return (s >> 1) | (fb << 15);
    endfunction

    // Sequence-level reference: per compare cycle c, stimulus bits and expected o1/o2 of the target
    logic exp_a [0:1023];
    logic exp_en[0:1023];
    int   m_err, m_first;
    logic [5:0] m_vec;

    task automatic model(input logic [15:0] sd, input int len, input int mode, input int k, input int lastc);
        logic [15:0] s;
        logic g1, g2, a, en, b1, b2;
        s = (sd == 16'h0) ? 16'hACE1 : sd;
        g1 = 1'b0; g2 = 1'b0;
        m_err = 0; m_first = 0; m_vec = '0;
        for (int c = 0; c <= len + 1; c++) begin
            a  = (c < len) ? s[0] : 1'b0;
            en = (c < len) ? s[1] : 1'b0;
            exp_a[c] = a;
            exp_en[c] = en;
            if (c <= lastc) begin
                b1 = (mode == 1 && c >= k) ? 1'b1 : g1;
                b2 = (mode == 2 && c >= k) ? 1'b1 : g2;
                if (b1 != g1 || b2 != g2) begin
                    if (m_err == 0) begin
                        m_first = c;
                        m_vec = {g1, g2, 1'b0, b1, b2, 1'b0};
                    end
                    m_err++;
                end
            end
            g2 = g1;
            if (en) g1 = a;
            if (c < len) s = lfsr_next(s);
        end
    endtask

    task automatic run_campaign(input string tag, input logic [15:0] sd, input int len,
                                input int mode, input int k, input int abort_at);
        int lastc, nb, cc, stim_bad, exp_busy;
        logic [5:0] vexp;
        lastc = (abort_at >= 0) ? abort_at : len + 1;
        model(sd, len, mode, k, lastc);
        fmode = mode;
        fk = k;
        @(negedge clk);
        seed = sd; run_len = CW'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; cc = 0; stim_bad = 0;
        while (busy && nb < 1000) begin
            if (!dut_reset && cc < 1000) begin
                if (dut_a !== exp_a[cc] || dut_enable !== exp_en[cc]) stim_bad++;
                if (cc == abort_at) abort = 1'b1;
                cc++;
            end
            nb++;
            @(negedge clk);
            abort = 1'b0;
        end
        exp_busy = (abort_at >= 0) ? RSTC + abort_at + 1 : RSTC + len + DRNC;
`ifdef FIAPP_CTRL_ERRLOG_EN
        vexp = m_vec;
`else
        vexp = 6'b0;
`endif
        chk({tag, " busy_cycles"}, nb, exp_busy);
        chk({tag, " stimulus_errs"}, stim_bad, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " pass"}, pass, (m_err == 0 && abort_at < 0) ? 1 : 0);
        chk({tag, " err_count"}, err_count, m_err);
        chk({tag, " first_err_cycle"}, first_err_cycle, m_first);
        chk({tag, " err_vec"}, err_vec, vexp);
        chk({tag, " dut_reset_low"}, dut_reset, 0);
    endtask

    initial begin
        int nb;
        reset = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; run_len = '0;
        start2 = 1'b0; run_len2 = 4'd15; t2o1 = 1'b0; t2o2 = 1'b0; t2o3 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst dut_reset", dut_reset, 1);
        chk("rst dut_a", dut_a, 0);
        chk("rst dut_enable", dut_enable, 0);
        chk("rst err_count", err_count, 0);
        chk("rst first_err", first_err_cycle, 0);
        chk("rst err_vec", err_vec, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle dut_reset", dut_reset, 0);

        run_campaign("clean", 16'h0001, 100, 0, 0, -1);
        run_campaign("o2_force", 16'h0001, 100, 2, 10, -1);
        run_campaign("seed0_len0", 16'h0000, 0, 0, 0, -1);
        run_campaign("seed0_len20", 16'h0000, 20, 0, 0, -1);
        run_campaign("abort", 16'h5A5A, 50, 0, 0, 5);
        run_campaign("restart_clean", 16'h0001, 100, 0, 0, -1);

        // Reset in the middle of a faulty run
        fmode = 1; fk = 0;
        @(negedge clk);
        seed = 16'h1234; run_len = CW'(30); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RSTC + 10) @(negedge clk);
        chk("mid busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid busy", busy, 0);
        chk("mid done", done, 0);
        chk("mid pass", pass, 0);
        chk("mid err_count", err_count, 0);
        chk("mid first_err", first_err_cycle, 0);
        chk("mid err_vec", err_vec, 0);
        chk("mid dut_reset", dut_reset, 1);
        chk("mid dut_a", dut_a, 0);
        chk("mid dut_enable", dut_enable, 0);
        run_campaign("after_reset", 16'hBEEF, 25, 0, 0, -1);

        for (int i = 0; i < 5; i++) begin
            logic [15:0] rs;
            int rl, rm, rk;
            rs = 16'($urandom);
            rl = int'($urandom_range(1, 60));
            rm = int'($urandom_range(0, 2));
            rk = int'($urandom_range(0, rl + 1));
            run_campaign($sformatf("rand%0d", i), rs, rl, rm, rk, -1);
        end
        run_campaign("rand_abort", 16'($urandom), 40, 1, 3, int'($urandom_range(0, 39)));

        // Narrow counters: every compare cycle mismatches on o3, so err_count saturates
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        nb = 0;
        while (busy2 && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        chk("sat busy_cycles", nb, RSTC + 15 + DRNC);
        chk("sat done", done2, 1);
        chk("sat pass", pass2, 0);
        chk("sat err_count", err_count2, 15);
        chk("sat first_err", first_err2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
